// File: rtl/fifo_rd_arbiter.sv
// Round-robin owner of the async FIFO read port in the clk_r domain.
// Grants committed bursts, paces red_enable against the pointer block's registered enable, and steers data.
module fifo_rd_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned BURST_MAX = 16,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned TIMEOUT   = 256,
  localparam int unsigned LW       = $clog2(BURST_MAX) + 1
) (
  input  logic               clk_r,
  input  logic               rst_r_gen,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*LW-1:0] req_len,
  input  logic               fifo_empty,
  input  logic               fifo_red_en,
  input  logic [WIDTH-1:0]   fifo_rdata,
  output logic               red_enable,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rd_valid,
  output logic [WIDTH-1:0]   rd_data,
  output logic [NREQ-1:0]    done,
  output logic               abort,
  output logic               busy
);

  localparam int unsigned LI = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, BURST, ABORT, DRAIN} state_t;

  state_t          r_state;
  logic [LW-1:0]   r_rem;
  logic            r_en_q;
  logic [TW-1:0]   r_tcnt;
  logic [LI-1:0]   r_last;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_rd_valid;
  logic [NREQ-1:0] r_done;
  logic            r_abort;

  logic            w_found;
  logic [LI-1:0]   w_win;
  logic [LI-1:0]   w_idx;
  logic [LW-1:0]   w_len_raw;
  logic [LW-1:0]   w_len;
  logic [LW-1:0]   w_rem_nxt;
  logic            w_red_enable;
  logic            w_unused;

  // Empty is already folded into the qualified strobe; it only feeds the sanity check.
  assign w_unused = fifo_empty;

  // First requester after the last winner, circular.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      w_idx = LI'((32'(r_last) + i) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Winner's length, with 0 and oversize both meaning a full burst.
  always_comb begin
    w_len_raw = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (LI'(i) == w_win) begin
        w_len_raw = req_len[i*LW +: LW];
      end
    end
    w_len = (w_len_raw == '0 || w_len_raw > LW'(BURST_MAX)) ? LW'(BURST_MAX) : w_len_raw;
  end

  assign w_rem_nxt    = (fifo_red_en && r_rem != '0) ? r_rem - LW'(1) : r_rem;
  assign w_red_enable = (r_state == BURST) && (r_rem > LW'(r_en_q));

  always_ff @(posedge clk_r or negedge rst_r_gen) begin
    if (!rst_r_gen) begin
      r_state    <= IDLE;
      r_rem      <= '0;
      r_en_q     <= 1'b0;
      r_tcnt     <= '0;
      r_last     <= LI'(NREQ - 1);
      r_gnt      <= '0;
      r_rd_valid <= '0;
      r_done     <= '0;
      r_abort    <= 1'b0;
    end else begin
      r_en_q     <= w_red_enable;
      r_rd_valid <= fifo_red_en ? r_gnt : '0;
      r_done     <= '0;
      r_abort    <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tcnt <= '0;
          if (w_found) begin
            r_gnt   <= NREQ'(1) << w_win;
            r_rem   <= w_len;
            r_last  <= w_win;
            r_state <= BURST;
          end
        end
        BURST: begin
          r_rem <= w_rem_nxt;
          if (fifo_red_en) begin
            r_tcnt <= '0;
            if (r_rem == LW'(1)) begin
              r_state <= DRAIN;
              r_done  <= r_gnt;
            end
          end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
            r_state <= ABORT;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        ABORT: begin
          // A strobe launched by the last BURST-cycle enable still lands here.
          r_rem   <= w_rem_nxt;
          r_state <= DRAIN;
          r_done  <= r_gnt;
          r_abort <= (w_rem_nxt != '0);
        end
        DRAIN: begin
          r_gnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign red_enable = w_red_enable;
  assign gnt        = r_gnt;
  assign rd_valid   = r_rd_valid;
  assign rd_data    = fifo_rdata;
  assign done       = r_done;
  assign abort      = r_abort;
  assign busy       = (r_state != IDLE);

  a_strobe_in_burst: assert property (@(posedge clk_r) disable iff (!rst_r_gen)
    fifo_red_en |-> ((r_state == BURST || r_state == ABORT) && !fifo_empty));

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: FIFO/pointer-block model, word and done scoreboards, vector table.
module tb_fifo_rd_arbiter;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned BURST_MAX = 16;
  localparam int unsigned WIDTH     = 32;
  localparam int unsigned TIMEOUT   = 8;
  localparam int unsigned LW        = $clog2(BURST_MAX) + 1;

  logic               clk_r     = 1'b0;
  logic               rst_r_gen = 1'b0;
  logic [NREQ-1:0]    req       = '0;
  logic [NREQ*LW-1:0] req_len   = '0;
  logic               fifo_empty;
  logic               fifo_red_en;
  logic [WIDTH-1:0]   fifo_rdata = '0;
  logic               red_enable;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rd_valid;
  logic [WIDTH-1:0]   rd_data;
  logic [NREQ-1:0]    done;
  logic               abort;
  logic               busy;

  fifo_rd_arbiter #(
    .NREQ(NREQ), .BURST_MAX(BURST_MAX), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_r(clk_r), .rst_r_gen(rst_r_gen), .req(req), .req_len(req_len),
    .fifo_empty(fifo_empty), .fifo_red_en(fifo_red_en), .fifo_rdata(fifo_rdata),
    .red_enable(red_enable), .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .abort(abort), .busy(busy)
  );

  always #5 clk_r = ~clk_r;

  int cyc = 0;
  always @(posedge clk_r) cyc <= cyc + 1;

  // Pointer block: registered enable, qualified strobe, data one cycle later.
  logic             p_en;
  int               f_cnt  = 0;
  int               wr_cnt = 0;
  logic             f_clr  = 1'b0;
  logic [WIDTH-1:0] rd_seq = WIDTH'(32'h1000);

  always @(posedge clk_r or negedge rst_r_gen) begin
    if (!rst_r_gen) p_en <= 1'b0;
    else            p_en <= red_enable;
  end
  assign fifo_empty  = (f_cnt == 0);
  assign fifo_red_en = p_en && !fifo_empty;
  always @(posedge clk_r) begin
    if (f_clr) f_cnt <= 0;
    else       f_cnt <= f_cnt + wr_cnt - (fifo_red_en ? 1 : 0);
    if (fifo_red_en) begin
      fifo_rdata <= rd_seq;
      rd_seq     <= rd_seq + WIDTH'(1);
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct { int owner; logic [WIDTH-1:0] data; } word_t;
  typedef struct { logic [NREQ-1:0] dvec; logic ab; } done_t;
  word_t exp_q[$];
  done_t done_q[$];
  logic [WIDTH-1:0] exp_idx = WIDTH'(32'h1000);

  task automatic push_word(input int o);
    exp_q.push_back('{o, exp_idx});
    exp_idx = exp_idx + WIDTH'(1);
  endtask

  task automatic push_done(input int o, input logic ab);
    done_q.push_back('{NREQ'(1) << o, ab});
  endtask

  int n_done   = 0;
  int n_rv     = 0;
  int n_str    = 0;
  int first_rv = -1;
  int last_done = -1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk_r) begin : mon
    word_t w;
    done_t d;
    if (fifo_red_en) n_str++;
    if (rd_valid != '0) begin
      n_rv++;
      if (first_rv < 0) first_rv = cyc;
      if (exp_q.size() == 0) chk("rv_unexpected", 64'(rd_valid), 64'(0));
      else begin
        w = exp_q.pop_front();
        chk("rv_owner", 64'(rd_valid), 64'(NREQ'(1) << w.owner));
        chk("rv_data", 64'(rd_data), 64'(w.data));
      end
    end
    if (done != '0) begin
      n_done++;
      last_done = cyc;
      if (done_q.size() == 0) chk("done_unexpected", 64'(done), 64'(0));
      else begin
        d = done_q.pop_front();
        chk("done_owner", 64'(done), 64'(d.dvec));
        chk("abort_flag", 64'(abort), 64'(d.ab));
      end
    end else if (abort) begin
      chk("abort_without_done", 64'(abort), 64'(0));
    end
  end

  task automatic step();
    @(negedge clk_r);
    #1;
  endtask

  task automatic fifo_load(input int n);
    f_clr = 1'b1;
    step();
    f_clr  = 1'b0;
    wr_cnt = n;
    step();
    wr_cnt = 0;
  endtask

  typedef struct {
    int owner; int len; int pre; int add_at; int add_n;
    int words; int done_at; bit ab; bit chk_re;
  } vec_t;
  vec_t vecs[10];

  task automatic run_vec(input vec_t v);
    int c0, rel, d0;
    fifo_load(v.pre);
    for (int k = 0; k < v.words; k++) push_word(v.owner);
    push_done(v.owner, v.ab);
    n_rv = 0; n_str = 0; first_rv = -1; d0 = n_done;
    req_len[v.owner*LW +: LW] = LW'(v.len);
    req[v.owner] = 1'b1;
    c0 = cyc; rel = 0;
    while (n_done == d0 && rel < 80) begin
      step();
      rel = cyc - c0;
      wr_cnt = (rel == v.add_at) ? v.add_n : 0;
      if (rel == 1) begin
        req[v.owner] = 1'b0;
        chk("gnt_cycle1", 64'(gnt), 64'(NREQ'(1) << v.owner));
        chk("red_enable_cycle1", 64'(red_enable), 64'(1));
      end
      if (v.chk_re && rel == v.done_at - 1) chk("red_enable_last_strobe", 64'(red_enable), 64'(0));
    end
    wr_cnt = 0;
    chk("done_count", 64'(n_done - d0), 64'(1));
    chk("done_cycle", 64'(last_done - c0), 64'(v.done_at));
    chk("rv_count", 64'(n_rv), 64'(v.words));
    chk("strobe_count", 64'(n_str), 64'(v.words));
    if (v.words > 0) chk("first_rv_cycle", 64'(first_rv - c0), 64'(3));
    chk("fifo_left", 64'(f_cnt), 64'(v.pre + v.add_n - v.words));
    step();
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_gnt", 64'(gnt), 64'(0));
    chk("word_sb_drained", 64'(exp_q.size()), 64'(0));
    chk("done_sb_drained", 64'(done_q.size()), 64'(0));
  endtask

  initial begin : main
    int c0, rel, d0, nd;
    int dc[5];
    int order[5];

    //          own len pre add@ addn words done ab re
    vecs[0] = '{0,  4,  10, -1,  0,   4,    6,  0, 1};
    vecs[1] = '{1,  1,   5, -1,  0,   1,    3,  0, 1};
    vecs[2] = '{2,  0,  20, -1,  0,  16,   18,  0, 1};
    vecs[3] = '{3, 20,  20, -1,  0,  16,   18,  0, 1};
    vecs[4] = '{0, 16,  16, -1,  0,  16,   18,  0, 1};
    vecs[5] = '{1,  5,   2, -1,  0,   2,   13,  1, 0};
    vecs[6] = '{2,  3,   0, -1,  0,   0,   10,  1, 0};
    vecs[7] = '{3,  3,   1,  5,  3,   3,    8,  0, 1};
    vecs[8] = '{0,  3,   1,  9,  2,   3,   12,  0, 1};
    vecs[9] = '{1,  3,   1, 10,  2,   2,   12,  1, 0};
    order   = '{0, 1, 2, 3, 0};

    repeat (3) step();
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_abort", 64'(abort), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_red_enable", 64'(red_enable), 64'(0));
    rst_r_gen = 1'b1;
    step();
    step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during word 2 of an 8-word burst.
    fifo_load(20);
    push_word(2);
    push_word(2);
    d0 = n_done;
    req_len[2*LW +: LW] = LW'(8);
    req[2] = 1'b1;
    c0 = cyc;
    step();
    req[2] = 1'b0;
    while (cyc - c0 < 4) step();
    #1;
    rst_r_gen = 1'b0;
    #1;
    chk("midrst_gnt", 64'(gnt), 64'(0));
    chk("midrst_rd_valid", 64'(rd_valid), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_abort", 64'(abort), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_red_enable", 64'(red_enable), 64'(0));
    step();
    step();
    chk("midrst_no_done", 64'(n_done - d0), 64'(0));
    chk("midrst_fifo_left", 64'(f_cnt), 64'(18));
    chk("midrst_sb_drained", 64'(exp_q.size()), 64'(0));
    rst_r_gen = 1'b1;
    step();

    // Round-robin from reset; req[2] joins while consumer 1 owns the port.
    fifo_load(20);
    foreach (order[k]) begin
      push_word(order[k]);
      push_done(order[k], 1'b0);
    end
    for (int i = 0; i < int'(NREQ); i++) req_len[i*LW +: LW] = LW'(1);
    req = '1;
    req[2] = 1'b0;
    d0 = n_done; nd = 0; c0 = cyc; rel = 0;
    while (nd < 5 && rel < 60) begin
      step();
      rel = cyc - c0;
      if (rel == 1) chk("rr_first_gnt", 64'(gnt), 64'(1));
      if (rel == 5) begin
        chk("rr_gnt1", 64'(gnt), 64'(NREQ'(1) << 1));
        req[2] = 1'b1;
      end
      if (rel == 6) chk("rr_no_preempt", 64'(gnt), 64'(NREQ'(1) << 1));
      if (n_done - d0 > nd) begin
        dc[nd] = last_done - c0;
        nd++;
        if (nd == 5) req = '0;
      end
    end
    chk("rr_done_count", 64'(nd), 64'(5));
    for (int k = 0; k < 5; k++) chk("rr_done_cycle", 64'(dc[k]), 64'(3 + 4 * k));
    step();
    step();
    chk("rr_idle_busy", 64'(busy), 64'(0));
    chk("rr_word_sb_drained", 64'(exp_q.size()), 64'(0));
    chk("rr_done_sb_drained", 64'(done_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
